// File: rtl/tt_mux_pkg.sv
// Shared types and width helpers for the clocked row multiplexer.
package tt_mux_pkg;

  typedef enum logic [1:0] {StIdle, StBreak, StGuard, StActive} mux_state_e;

  function automatic int unsigned calc_u_ow(input int unsigned n_o, input int unsigned n_io);
    return n_o + 2 * n_io;
  endfunction

  function automatic int unsigned calc_u_iw(input int unsigned n_i, input int unsigned n_io);
    return n_i + n_io;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned n_um);
    return (n_um > 1) ? $clog2(n_um) : 1;
  endfunction

endpackage

// File: rtl/tt_mux_col_dec.sv
// Binary column + enable to registered one-hot-or-zero UM enable.
module tt_mux_col_dec #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [CW-1:0] i_col,
  input  logic          i_ena,
  output logic [N-1:0]  o_onehot
);

  logic [N-1:0] w_onehot_d;
  logic [N-1:0] r_onehot;

  always_comb begin
    w_onehot_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (i_ena && (int'(i_col) == i)) w_onehot_d[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_onehot <= '0;
    else       r_onehot <= w_onehot_d;
  end

  assign o_onehot = r_onehot;

endmodule

// File: rtl/tt_mux_seq.sv
// Clocked row multiplexer: break-before-make column switching with a programmable guard gap.
module tt_mux_seq
  import tt_mux_pkg::*;
#(
  parameter int unsigned N_UM      = 8,
  parameter int unsigned N_IO      = 8,
  parameter int unsigned N_O       = 8,
  parameter int unsigned N_I       = 10,
  parameter int unsigned ROW_AW    = 5,
  parameter int unsigned GUARD_CYC = 2,
  parameter int unsigned IN_REG    = 1,
  parameter int unsigned OUT_REG   = 1,
  localparam int unsigned U_OW     = calc_u_ow(N_O, N_IO),
  localparam int unsigned U_IW     = calc_u_iw(N_I, N_IO),
  localparam int unsigned CW       = calc_cw(N_UM)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [ROW_AW-1:0]      i_addr,
  input  logic                   i_sel_valid,
  output logic                   o_sel_ready,
  input  logic [ROW_AW-1:0]      i_sel_branch,
  input  logic [CW-1:0]          i_sel_col,
  input  logic                   i_sel_ena,
  input  logic [U_IW-1:0]        i_si_usr,
  output logic [U_OW-1:0]        o_so_usr,
  output logic                   o_so_oe,
  input  logic [U_OW*N_UM-1:0]   i_um_ow,
  output logic [U_IW*N_UM-1:0]   o_um_iw,
  output logic [N_UM-1:0]        o_um_ena,
  output logic [CW-1:0]          o_cur_col,
  output logic                   o_active
);

  mux_state_e      r_state, w_state_d;
  logic [CW-1:0]   r_col, w_col_d;
  logic            r_conn, w_conn_d;
  logic [3:0]      r_cnt, w_cnt_d;
  logic            r_so_oe;
  logic            w_accept, w_connect;
  logic [N_UM-1:0] w_um_ena;
  logic [U_IW-1:0] w_in_data;
  logic [U_OW-1:0] w_so_mux, w_so_data;

  assign o_sel_ready = (r_state == StIdle) || (r_state == StActive);
  assign w_accept    = i_sel_valid && o_sel_ready;
  assign w_connect   = (i_sel_branch == i_addr) && i_sel_ena && (int'(i_sel_col) < int'(N_UM));

  always_comb begin
    w_state_d = r_state;
    w_col_d   = r_col;
    w_conn_d  = r_conn;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept && w_connect) begin
          w_state_d = StBreak;
          w_col_d   = i_sel_col;
          w_conn_d  = 1'b1;
        end
      end
      StBreak: begin
        if (GUARD_CYC > 0) begin
          w_state_d = StGuard;
          w_cnt_d   = 4'(GUARD_CYC - 1);
        end else begin
          w_state_d = r_conn ? StActive : StIdle;
        end
      end
      StGuard: begin
        if (r_cnt == 4'd0) w_state_d = r_conn ? StActive : StIdle;
        else               w_cnt_d   = r_cnt - 4'd1;
      end
      StActive: begin
        // Reconnecting the column already in use must not open a gap.
        if (w_accept && !(w_connect && (i_sel_col == r_col))) begin
          w_state_d = StBreak;
          w_conn_d  = w_connect;
          if (w_connect) w_col_d = i_sel_col;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_col   <= '0;
      r_conn  <= 1'b0;
      r_cnt   <= '0;
      r_so_oe <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_col   <= w_col_d;
      r_conn  <= w_conn_d;
      r_cnt   <= w_cnt_d;
      r_so_oe <= (r_state == StActive) && (w_state_d == StActive);
    end
  end

  tt_mux_col_dec #(
    .N  (N_UM),
    .CW (CW)
  ) u_col_dec (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_col    (w_col_d),
    .i_ena    (w_state_d == StActive),
    .o_onehot (w_um_ena)
  );

  assign o_um_ena  = w_um_ena;
  assign o_active  = (r_state == StActive);
  assign o_cur_col = o_active ? r_col : '0;
  assign o_so_oe   = r_so_oe;

  // Input register only samples while ACTIVE so a new column starts from zero.
  if (IN_REG != 0) begin : g_in_reg
    logic [U_IW-1:0] r_si;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_si <= '0;
      else       r_si <= (r_state == StActive) ? i_si_usr : '0;
    end
    assign w_in_data = r_si;
  end else begin : g_in_comb
    assign w_in_data = i_si_usr;
  end

  for (genvar i = 0; i < int'(N_UM); i++) begin : g_um_iw
    assign o_um_iw[U_IW*i +: U_IW] = w_um_ena[i] ? w_in_data : '0;
  end

  always_comb begin
    w_so_mux = '0;
    for (int i = 0; i < int'(N_UM); i++) begin
      if (int'(r_col) == i) w_so_mux = i_um_ow[U_OW*i +: U_OW];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [U_OW-1:0] r_so;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_so <= '0;
      else       r_so <= w_so_mux;
    end
    assign w_so_data = r_so;
  end else begin : g_out_comb
    assign w_so_data = w_so_mux;
  end

  assign o_so_usr = r_so_oe ? w_so_data : '0;

endmodule

// File: tb/tb_tt_mux_seq.sv
// Directed self-checking bench: registered row (guard 2) plus a combinational row (guard 0, 6 UMs).
module tb_tt_mux_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int inv_bad  = 0;

  // Row A: defaults, N_UM=8, U_OW=24, U_IW=18, CW=3
  logic [4:0]    addr_a = 5'd5;
  logic          valid_a = 1'b0, ready_a, ena_a = 1'b0;
  logic [4:0]    branch_a = '0;
  logic [2:0]    col_a = '0, cur_col_a;
  logic [17:0]   si_a = '0;
  logic [23:0]   so_a;
  logic          so_oe_a, active_a;
  logic [191:0]  um_ow_a;
  logic [143:0]  um_iw_a;
  logic [7:0]    um_ena_a, prev_ena_a;

  // Row B: N_UM=6, no guard, no pipeline registers
  logic [4:0]    addr_b = 5'd3;
  logic          valid_b = 1'b0, ready_b, ena_b = 1'b0;
  logic [4:0]    branch_b = '0;
  logic [2:0]    col_b = '0, cur_col_b;
  logic [17:0]   si_b = '0;
  logic [23:0]   so_b;
  logic          so_oe_b, active_b;
  logic [143:0]  um_ow_b;
  logic [107:0]  um_iw_b;
  logic [5:0]    um_ena_b;

  tt_mux_seq dut_a (
    .i_clk(clk), .i_rst(rst), .i_addr(addr_a), .i_sel_valid(valid_a), .o_sel_ready(ready_a),
    .i_sel_branch(branch_a), .i_sel_col(col_a), .i_sel_ena(ena_a), .i_si_usr(si_a),
    .o_so_usr(so_a), .o_so_oe(so_oe_a), .i_um_ow(um_ow_a), .o_um_iw(um_iw_a),
    .o_um_ena(um_ena_a), .o_cur_col(cur_col_a), .o_active(active_a)
  );

  tt_mux_seq #(
    .N_UM(6), .GUARD_CYC(0), .IN_REG(0), .OUT_REG(0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_addr(addr_b), .i_sel_valid(valid_b), .o_sel_ready(ready_b),
    .i_sel_branch(branch_b), .i_sel_col(col_b), .i_sel_ena(ena_b), .i_si_usr(si_b),
    .o_so_usr(so_b), .o_so_oe(so_oe_b), .i_um_ow(um_ow_b), .o_um_iw(um_iw_b),
    .o_um_ena(um_ena_b), .o_cur_col(cur_col_b), .o_active(active_b)
  );

  // Continuous invariants on row A: one-hot-or-zero, so_oe backed by enable, no direct swap.
  always @(negedge clk) begin
    if (rst) begin
      prev_ena_a = '0;
    end else begin
      if ($countones(um_ena_a) > 1) inv_bad++;
      if (so_oe_a && !um_ena_a[cur_col_a]) inv_bad++;
      if ((prev_ena_a != 0) && (um_ena_a != 0) && (prev_ena_a != um_ena_a)) inv_bad++;
      prev_ena_a = um_ena_a;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req_a(input logic [4:0] br, input logic [2:0] c, input logic e);
    valid_a = 1'b1; branch_a = br; col_a = c; ena_a = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) um_ow_a[24*i +: 24] = 24'hAB0000 + 24'(i) * 24'h000101;
    for (int i = 0; i < 6; i++) um_ow_b[24*i +: 24] = 24'hBE0000 + 24'(i) * 24'h000101;

    tick(1);
    chk("rst_ready", 64'(ready_a), 64'd1);
    chk("rst_ena", 64'(um_ena_a), 64'h0);
    chk("rst_oe", 64'(so_oe_a), 64'd0);
    chk("rst_active", 64'(active_a), 64'd0);
    chk("rst_iw_zero", 64'(um_iw_a == '0), 64'd1);
    chk("rst_so", 64'(so_a), 64'h0);
    rst = 1'b0;
    tick(1);

    // Connect col 3: enable at t+4, so_oe at t+5
    req_a(5'd5, 3'd3, 1'b1);
    tick(1);
    valid_a = 1'b0;
    chk("c3_break_ready", 64'(ready_a), 64'd0);
    tick(2);
    chk("c3_guard_ena", 64'(um_ena_a), 64'h0);
    tick(1);
    chk("c3_ena_t4", 64'(um_ena_a), 64'h08);
    chk("c3_oe_t4", 64'(so_oe_a), 64'd0);
    chk("c3_curcol", 64'(cur_col_a), 64'd3);
    chk("c3_active", 64'(active_a), 64'd1);
    tick(1);
    chk("c3_oe_t5", 64'(so_oe_a), 64'd1);
    chk("c3_so", 64'(so_a), 64'hAB0303);

    // Switch to col 6 with fresh input data
    si_a = 18'h0A5A5;
    req_a(5'd5, 3'd6, 1'b1);
    tick(1);
    valid_a = 1'b0;
    chk("c6_break_ena", 64'(um_ena_a), 64'h0);
    chk("c6_break_oe", 64'(so_oe_a), 64'd0);
    chk("c6_break_iw", 64'(um_iw_a == '0), 64'd1);
    tick(1);
    chk("c6_gap2", 64'(um_ena_a), 64'h0);
    tick(1);
    chk("c6_gap3", 64'(um_ena_a), 64'h0);
    tick(1);
    chk("c6_ena", 64'(um_ena_a), 64'h40);
    chk("c6_iw_first", 64'(um_iw_a[18*6 +: 18]), 64'h0);
    tick(1);
    chk("c6_iw_data", 64'(um_iw_a[18*6 +: 18]), 64'h0A5A5);
    chk("c6_iw_col3", 64'(um_iw_a[18*3 +: 18]), 64'h0);
    chk("c6_so", 64'(so_a), 64'hAB0606);

    // Same column again: no gap
    req_a(5'd5, 3'd6, 1'b1);
    tick(1);
    valid_a = 1'b0;
    chk("same_ena", 64'(um_ena_a), 64'h40);
    chk("same_oe", 64'(so_oe_a), 64'd1);
    chk("same_ready", 64'(ready_a), 64'd1);

    // Other row's branch: disconnect through BREAK, GUARD, GUARD
    req_a(5'd4, 3'd6, 1'b1);
    tick(1);
    valid_a = 1'b0;
    chk("dis_ready1", 64'(ready_a), 64'd0);
    chk("dis_oe", 64'(so_oe_a), 64'd0);
    chk("dis_ena", 64'(um_ena_a), 64'h0);
    tick(2);
    chk("dis_ready3", 64'(ready_a), 64'd0);
    tick(1);
    chk("dis_idle_ready", 64'(ready_a), 64'd1);
    chk("dis_idle_active", 64'(active_a), 64'd0);
    chk("dis_idle_ena", 64'(um_ena_a), 64'h0);
    chk("dis_idle_so", 64'(so_a), 64'h0);

    // addr change while ACTIVE is ignored
    req_a(5'd5, 3'd1, 1'b1);
    tick(1);
    valid_a = 1'b0;
    tick(3);
    chk("c1_ena", 64'(um_ena_a), 64'h02);
    addr_a = 5'd7;
    tick(2);
    chk("addr_chg_ena", 64'(um_ena_a), 64'h02);
    chk("addr_chg_so", 64'(so_a), 64'hAB0101);
    addr_a = 5'd5;

    // Reset while in GUARD clears outputs immediately
    req_a(5'd5, 3'd2, 1'b1);
    tick(1);
    valid_a = 1'b0;
    tick(1);
    chk("pre_rst_ready", 64'(ready_a), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ready_a), 64'd1);
    chk("mid_rst_ena", 64'(um_ena_a), 64'h0);
    chk("mid_rst_oe", 64'(so_oe_a), 64'd0);
    chk("mid_rst_iw", 64'(um_iw_a == '0), 64'd1);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Row B: guard 0, combinational data paths
    si_b = 18'h15A5A;
    valid_b = 1'b1; branch_b = 5'd3; col_b = 3'd5; ena_b = 1'b1;
    tick(1);
    valid_b = 1'b0;
    chk("b_break_ready", 64'(ready_b), 64'd0);
    chk("b_break_ena", 64'(um_ena_b), 64'h0);
    tick(1);
    chk("b_ena", 64'(um_ena_b), 64'h20);
    chk("b_curcol", 64'(cur_col_b), 64'd5);
    chk("b_iw_comb", 64'(um_iw_b[18*5 +: 18]), 64'h15A5A);
    chk("b_oe_first", 64'(so_oe_b), 64'd0);
    tick(1);
    chk("b_oe", 64'(so_oe_b), 64'd1);
    chk("b_so", 64'(so_b), 64'hBE0505);
    um_ow_b[24*5 +: 24] = 24'h123456;
    #1;
    chk("b_so_comb", 64'(so_b), 64'h123456);

    // Out-of-range column is a disconnect
    valid_b = 1'b1; branch_b = 5'd3; col_b = 3'd7; ena_b = 1'b1;
    tick(1);
    valid_b = 1'b0;
    chk("b_oor_break", 64'(um_ena_b), 64'h0);
    chk("b_oor_oe", 64'(so_oe_b), 64'd0);
    tick(1);
    chk("b_oor_idle", 64'(active_b), 64'd0);
    chk("b_oor_ready", 64'(ready_b), 64'd1);
    chk("b_oor_iw", 64'(um_iw_b == '0), 64'd1);

    chk("inv_row_a", 64'(inv_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
